pipe_stage_buffer: RTL and testbench

Parametrised inter-stage pipeline register for the LC-3b datapath. It replaces the plain load-enabled latch between stages with a valid/ready handshake, an optional 2-entry skid, a synchronous flush for branch squash, and stall instrumentation. The payload is an opaque bit vector. Stage wrappers pack the instruction, PC, ALU, MAR/MDR and register fields into it.

---
 rtl/pipe_stage_buffer.sv | 99 +++++++++
 tb/tb_pipe_stage_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// synchronous flush for branch squash and a saturating stall counter.
module pipe_stage_buffer #(
  parameter int WIDTH     = 16,
  parameter int SKID      = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 flush,
  input  logic                 clr_stats,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_count
);

  logic                 main_vld_p0;
  logic [WIDTH-1:0]     main_data_p0;
  logic                 skid_vld_p0;
  logic [CNT_WIDTH-1:0] stall_cnt_p0;
  logic                 in_fire;
  logic                 out_fire;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign out_valid   = main_vld_p0 & ~flush;
  assign out_data    = main_data_p0;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign occupancy   = {1'b0, main_vld_p0} + {1'b0, skid_vld_p0};
  assign stall_count = stall_cnt_p0;

  // stage p0: main register plus optional skid entry
  if (SKID != 0) begin : g_skid
    logic [WIDTH-1:0] skid_data_p0;

    // skid_vld_p0 is registered, so only flush reaches in_ready combinationally
    assign in_ready = ~skid_vld_p0 & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        main_vld_p0  <= 1'b0;
        skid_vld_p0  <= 1'b0;
        main_data_p0 <= '0;
        skid_data_p0 <= '0;
      end else if (flush) begin
        main_vld_p0 <= 1'b0;
        skid_vld_p0 <= 1'b0;
      end else if (out_fire && skid_vld_p0) begin
        main_data_p0 <= skid_data_p0;
        skid_vld_p0  <= 1'b0;
      end else if (in_fire && (!main_vld_p0 || out_fire)) begin
        main_data_p0 <= in_data;
        main_vld_p0  <= 1'b1;
      end else if (in_fire) begin
        skid_data_p0 <= in_data;
        skid_vld_p0  <= 1'b1;
      end else if (out_fire) begin
        main_vld_p0 <= 1'b0;
      end
    end
  end else begin : g_noskid
    assign skid_vld_p0 = 1'b0;
    assign in_ready    = (~main_vld_p0 | out_ready) & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        main_vld_p0  <= 1'b0;
        main_data_p0 <= '0;
      end else if (flush) begin
        main_vld_p0 <= 1'b0;
      end else if (in_fire) begin
        main_data_p0 <= in_data;
        main_vld_p0  <= 1'b1;
      end else if (out_fire) begin
        main_vld_p0 <= 1'b0;
      end
    end
  end

  // stall instrumentation, observed on the same edge as the handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_p0 <= '0;
    end else if (clr_stats) begin
      stall_cnt_p0 <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: SKID=1 and SKID=0 instances share stimulus and are
// checked every cycle against queue-based models, plus directed literal checks.
module tb_pipe_stage_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        clr_stats = 1'b0;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [15:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;
  logic [3:0]  stall1, stall0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.WIDTH(16), .SKID(1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .flush(flush), .clr_stats(clr_stats),
    .occupancy(occ1), .stall_count(stall1));

  pipe_stage_buffer #(.WIDTH(16), .SKID(0), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .flush(flush), .clr_stats(clr_stats),
    .occupancy(occ0), .stall_count(stall0));

  // Behavioural model: each stage is a FIFO of capacity 2 (skid) or 1 (plain).
  logic [15:0] q1[$];
  logic [15:0] q0[$];
  int cnt1 = 0;
  int cnt0 = 0;

  function automatic bit m_in_ready(int sz, bit skid);
    if (flush) return 1'b0;
    return skid ? (sz < 2) : (sz == 0 || out_ready);
  endfunction

  function automatic bit m_out_valid(int sz);
    return !flush && sz > 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0;
    end else begin
      bit inf1, outf1, st1, inf0, outf0, st0;
      inf1  = in_valid && m_in_ready(q1.size(), 1'b1);
      outf1 = m_out_valid(q1.size()) && out_ready;
      st1   = m_out_valid(q1.size()) && !out_ready;
      inf0  = in_valid && m_in_ready(q0.size(), 1'b0);
      outf0 = m_out_valid(q0.size()) && out_ready;
      st0   = m_out_valid(q0.size()) && !out_ready;
      if (flush) q1.delete();
      else begin
        if (outf1) void'(q1.pop_front());
        if (inf1) q1.push_back(in_data);
      end
      if (flush) q0.delete();
      else begin
        if (outf0) void'(q0.pop_front());
        if (inf0) q0.push_back(in_data);
      end
      if (clr_stats) cnt1 = 0; else if (st1 && cnt1 < 15) cnt1++;
      if (clr_stats) cnt0 = 0; else if (st0 && cnt0 < 15) cnt0++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("m1_in_ready", 32'(in_ready1), 32'(m_in_ready(q1.size(), 1'b1)));
    chk("m1_out_valid", 32'(out_valid1), 32'(m_out_valid(q1.size())));
    chk("m1_occ", 32'(occ1), 32'(q1.size()));
    chk("m1_stall", 32'(stall1), 32'(cnt1));
    if (out_valid1 && q1.size() > 0) chk("m1_data", 32'(out_data1), 32'(q1[0]));
    chk("m0_in_ready", 32'(in_ready0), 32'(m_in_ready(q0.size(), 1'b0)));
    chk("m0_out_valid", 32'(out_valid0), 32'(m_out_valid(q0.size())));
    chk("m0_occ", 32'(occ0), 32'(q0.size()));
    chk("m0_stall", 32'(stall0), 32'(cnt0));
    if (out_valid0 && q0.size() > 0) chk("m0_data", 32'(out_data0), 32'(q0[0]));
    if (occ0 > 2'd1) chk("m0_occ_max", 32'(occ0), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; clr_stats = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready_during", 32'(in_ready1), 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_out_data", 32'(out_data1), 32'd0);
    chk("rst_occ", 32'(occ1), 32'd0);
    chk("rst_stall", 32'(stall1), 32'd0);
    chk("rst_in_ready", 32'(in_ready1), 32'd1);

    // streaming 0x1000..0x1007
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'h1000 + 16'(i);
      chk("stream_in_ready", 32'(in_ready1), 32'd1);
      tick();
      chk("stream_valid", 32'(out_valid1), 32'd1);
      chk("stream_data", 32'(out_data1), 32'h1000 + 32'(i));
    end
    idle(2);

    // backpressure with 0xA1..0xA3
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A1; tick();
    in_data = 16'h00A2; tick();
    in_data = 16'h00A3;
    chk("bp_occ2", 32'(occ1), 32'd2);
    chk("bp_in_ready0", 32'(in_ready1), 32'd0);
    repeat (2) tick();
    chk("bp_hold_data", 32'(out_data1), 32'h00A1);
    out_ready = 1'b1;
    chk("bp_first", 32'(out_data1), 32'h00A1);
    tick();
    chk("bp_second", 32'(out_data1), 32'h00A2);
    tick();
    in_valid = 1'b0;
    chk("bp_third", 32'(out_data1), 32'h00A3);
    tick();
    chk("bp_drained", 32'(out_valid1), 32'd0);
    chk("bp_stalls", 32'(stall1), 32'd3);

    // flush with occupancy 2
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00B1; tick();
    in_data = 16'h00B2; tick();
    chk("fl_occ2", 32'(occ1), 32'd2);
    flush = 1'b1; in_data = 16'hBEEF; #1;
    chk("fl_out_valid", 32'(out_valid1), 32'd0);
    chk("fl_in_ready", 32'(in_ready1), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ0", 32'(occ1), 32'd0);
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("fl_no_emit", 32'(out_valid1), 32'd0);
    end

    // stall counter saturation
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00C1; tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_15", 32'(stall1), 32'd15);
    clr_stats = 1'b1; tick();
    chk("sat_clr", 32'(stall1), 32'd0);
    clr_stats = 1'b0;

    // SKID=0: held C1, out_ready lifts in_ready in the same cycle
    in_valid = 1'b1; in_data = 16'h00C2; #1;
    chk("s0_full_ready0", 32'(in_ready0), 32'd0);
    out_ready = 1'b1; #1;
    chk("s0_ready_comb", 32'(in_ready0), 32'd1);
    tick();
    chk("s0_swap_data", 32'(out_data0), 32'h00C2);
    chk("s0_swap_occ", 32'(occ0), 32'd1);
    idle(3);

    // asynchronous reset mid-cycle with occupancy 2
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00D1; tick();
    in_data = 16'h00D2; tick();
    in_valid = 1'b0;
    chk("ar_occ2", 32'(occ1), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid1), 32'd0);
    chk("ar_occ", 32'(occ1), 32'd0);
    chk("ar_stall", 32'(stall1), 32'd0);
    chk("ar_in_ready", 32'(in_ready1), 32'd1);
    tick();
    #2 reset_n = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      clr_stats = ($urandom_range(0, 63) == 0);
      if (i == 700) begin
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      tick();
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
